// File: rtl/core_pkg.sv
// Shared encodings for the 32-bit core: ALU control codes, instruction classes,
// field positions, decode-stage state and the bundle handed to execute.
package core_pkg;

  localparam logic [3:0] ALU_MV0   = 4'h0;
  localparam logic [3:0] ALU_MV1   = 4'h1;
  localparam logic [3:0] ALU_MV2   = 4'h2;
  localparam logic [3:0] ALU_MV3   = 4'h3;
  localparam logic [3:0] ALU_SHRA  = 4'h4;
  localparam logic [3:0] ALU_SHRL  = 4'h5;
  localparam logic [3:0] ALU_ROR   = 4'h6;
  localparam logic [3:0] ALU_SHL   = 4'h7;
  localparam logic [3:0] ALU_ROL   = 4'h8;
  localparam logic [3:0] ALU_NOT   = 4'h9;
  localparam logic [3:0] ALU_XOR   = 4'hA;
  localparam logic [3:0] ALU_OR    = 4'hB;
  localparam logic [3:0] ALU_AND   = 4'hC;
  localparam logic [3:0] ALU_SUB   = 4'hD;
  localparam logic [3:0] ALU_ADD   = 4'hE;
  localparam logic [3:0] ALU_PASSB = 4'hF;

  localparam logic [1:0] CLS_R   = 2'b00;
  localparam logic [1:0] CLS_I   = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  localparam logic [3:0] OP_BRZ  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int CLS_MSB   = 31;
  localparam int CLS_LSB   = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 26;
  localparam int RD_MSB    = 25;
  localparam int RD_LSB    = 21;
  localparam int RS_MSB    = 20;
  localparam int RS_LSB    = 16;
  localparam int RT_MSB    = 15;
  localparam int RT_LSB    = 11;
  localparam int IMM16_MSB = 15;
  localparam int IMM8_MSB  = 7;

  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wr_en;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_data;
    logic        branch;
  } ex_bundle_t;

  // Byte-move ops (mv0..mv3) take their A operand from the destination register.
  function automatic logic is_mv(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/decode_stage_operand_fwd.sv
// Resolves one source register: r0 is zero, then EX forward, then MEM forward,
// then the register-file read.
module operand_fwd (
  input  logic [4:0]  r,
  input  logic [31:0] rf_data,
  input  logic        ex_fwd_valid,
  input  logic [4:0]  ex_fwd_rd,
  input  logic [31:0] ex_fwd_data,
  input  logic        mem_fwd_valid,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  output logic [31:0] val
);

  always_comb begin
    if (r == 5'd0)
      val = '0;
    else if (ex_fwd_valid && (ex_fwd_rd == r))
      val = ex_fwd_data;
    else if (mem_fwd_valid && (mem_fwd_rd == r))
      val = mem_fwd_data;
    else
      val = rf_data;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, operand forwarding, load-use stall, flush and halt.
//   state  | meaning
//   RUN    | accepting and issuing one instruction per cycle
//   STALL  | bubble issued for a load-use hazard; held instruction re-offered
//   HALTED | halt issued; no further acceptance until reset
module decode_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  output logic [4:0]  rf_raddr0,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata0,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        ex_fwd_valid,
  input  logic [4:0]  ex_fwd_rd,
  input  logic [31:0] ex_fwd_data,
  input  logic        mem_fwd_valid,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_ctrl,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [4:0]  ex_rd,
  output logic        ex_wr_en,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic [31:0] ex_store_data,
  output logic        ex_branch,
  output logic        halted
);

  logic [1:0]  cls;
  logic [3:0]  op;
  logic [4:0]  rd, rs, rt;
  logic [15:0] imm16;
  logic [7:0]  imm8;
  logic [31:0] val_rs, val_rt, val_rd;

  assign cls   = if_instr[CLS_MSB:CLS_LSB];
  assign op    = if_instr[OP_MSB:OP_LSB];
  assign rd    = if_instr[RD_MSB:RD_LSB];
  assign rs    = if_instr[RS_MSB:RS_LSB];
  assign rt    = if_instr[RT_MSB:RT_LSB];
  assign imm16 = if_instr[IMM16_MSB:0];
  assign imm8  = if_instr[IMM8_MSB:0];

  assign rf_raddr0 = rs;
  assign rf_raddr1 = rt;
  assign rf_raddr2 = rd;

  operand_fwd u_fwd_rs (
    .r(rs), .rf_data(rf_rdata0),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .val(val_rs)
  );

  operand_fwd u_fwd_rt (
    .r(rt), .rf_data(rf_rdata1),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .val(val_rt)
  );

  operand_fwd u_fwd_rd (
    .r(rd), .rf_data(rf_rdata2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .val(val_rd)
  );

  ex_bundle_t dec;
  logic       use_rs, use_rt, use_rd, is_halt;

  always_comb begin
    dec     = '0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    use_rd  = 1'b0;
    is_halt = 1'b0;
    case (cls)
      CLS_R: begin
        dec.alu_ctrl = op;
        dec.rd       = rd;
        dec.wr_en    = (rd != 5'd0);
        dec.b        = val_rs;
        dec.a        = is_mv(op) ? val_rd : val_rt;
        use_rs       = 1'b1;
        use_rt       = !is_mv(op);
        use_rd       = is_mv(op);
      end
      CLS_I: begin
        dec.alu_ctrl = op;
        dec.rd       = rd;
        dec.wr_en    = (rd != 5'd0);
        use_rs       = 1'b1;
        if (is_mv(op)) begin
          dec.a  = val_rd;
          dec.b  = {24'd0, imm8};
          use_rd = 1'b1;
        end else begin
          dec.a = {16'd0, imm16};
          dec.b = val_rs;
        end
      end
      CLS_MEM: begin
        dec.alu_ctrl = ALU_ADD;
        dec.rd       = rd;
        dec.a        = {{16{imm16[15]}}, imm16};
        dec.b        = val_rs;
        use_rs       = 1'b1;
        if (op[3]) begin
          dec.mem_wr     = 1'b1;
          dec.store_data = val_rd;
          use_rd         = 1'b1;
        end else begin
          dec.mem_rd = 1'b1;
          dec.wr_en  = (rd != 5'd0);
        end
      end
      default: begin
        if (op == OP_BRZ) begin
          dec.alu_ctrl = ALU_PASSB;
          dec.a        = {{16{imm16[15]}}, imm16};
          dec.b        = val_rs;
          dec.branch   = 1'b1;
          use_rs       = 1'b1;
        end else if (op == OP_HALT) begin
          is_halt = 1'b1;
        end
      end
    endcase
  end

  state_t     state;
  ex_bundle_t ex_q;
  logic       ex_valid_q, halted_q;
  logic       hazard, accept;

  // A load still in EX cannot forward yet; a consumer of its rd waits one cycle.
  assign hazard = if_valid && (state != HALTED) && ex_valid_q && ex_q.mem_rd &&
                  (ex_q.rd != 5'd0) &&
                  ((use_rs && (rs == ex_q.rd)) ||
                   (use_rt && (rt == ex_q.rd)) ||
                   (use_rd && (rd == ex_q.rd)));

  assign if_ready = !rst && (state != HALTED) && !hazard && !ex_hold;
  assign accept   = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      halted_q   <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      if (state != HALTED)
        state <= RUN;
    end else if (!ex_hold) begin
      case (state)
        HALTED: begin
          ex_valid_q <= 1'b0;
          ex_q       <= '0;
        end
        default: begin
          if (hazard) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            state      <= STALL;
          end else if (accept && is_halt) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            halted_q   <= 1'b1;
            state      <= HALTED;
          end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_q       <= dec;
            state      <= RUN;
          end else begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            state      <= RUN;
          end
        end
      endcase
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_a          = ex_q.a;
  assign ex_b          = ex_q.b;
  assign ex_rd         = ex_q.rd;
  assign ex_wr_en      = ex_q.wr_en;
  assign ex_mem_rd     = ex_q.mem_rd;
  assign ex_mem_wr     = ex_q.mem_wr;
  assign ex_store_data = ex_q.store_data;
  assign ex_branch     = ex_q.branch;
  assign halted        = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, directed stall/flush/hold/halt
// sequences, then random traffic against a behavioural model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [4:0]  rf_raddr0, rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata0, rf_rdata1, rf_rdata2;
  logic        ex_fwd_valid, mem_fwd_valid;
  logic [4:0]  ex_fwd_rd, mem_fwd_rd;
  logic [31:0] ex_fwd_data, mem_fwd_data;
  logic        flush, ex_hold;
  logic        ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch, halted;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_rd;

  logic [31:0] rf [32];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign rf_rdata0 = rf[rf_raddr0];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  decode_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_store_data(ex_store_data), .ex_branch(ex_branch), .halted(halted)
  );

  typedef struct packed {
    logic        v;
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wr;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic        br;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk_r(input logic [1:0] c, input logic [3:0] o,
                                       input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return {c, o, d, s, t, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [1:0] c, input logic [3:0] o,
                                       input logic [4:0] d, input logic [4:0] s, input logic [15:0] imm);
    return {c, o, d, s, imm};
  endfunction

  function automatic exp_t ex(input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic wr, input logic mr, input logic mw,
                              input logic [31:0] sd, input logic br);
    exp_t e;
    e = '{v: 1'b1, alu: alu, a: a, b: b, rd: rd, wr: wr, mr: mr, mw: mw, sd: sd, br: br};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.v});
    chk({tag, ".alu"}, {28'd0, ex_alu_ctrl}, {28'd0, e.alu});
    chk({tag, ".a"}, ex_a, e.a);
    chk({tag, ".b"}, ex_b, e.b);
    chk({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    chk({tag, ".wr_en"}, {31'd0, ex_wr_en}, {31'd0, e.wr});
    chk({tag, ".mem_rd"}, {31'd0, ex_mem_rd}, {31'd0, e.mr});
    chk({tag, ".mem_wr"}, {31'd0, ex_mem_wr}, {31'd0, e.mw});
    chk({tag, ".store_data"}, ex_store_data, e.sd);
    chk({tag, ".branch"}, {31'd0, ex_branch}, {31'd0, e.br});
  endtask

  // Operand value as the architecture defines it: r0, then youngest forward, then register file.
  function automatic logic [31:0] mval(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (ex_fwd_valid && ex_fwd_rd == r) return ex_fwd_data;
    if (mem_fwd_valid && mem_fwd_rd == r) return mem_fwd_data;
    return rf[r];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    int cls, op, rd, rs, rt;
    logic [31:0] sext, zext16, zext8;
    cls = int'(ins[31:30]); op = int'(ins[29:26]);
    rd = int'(ins[25:21]); rs = int'(ins[20:16]); rt = int'(ins[15:11]);
    sext = {{16{ins[15]}}, ins[15:0]};
    zext16 = {16'd0, ins[15:0]};
    zext8 = {24'd0, ins[7:0]};
    e = '0;
    e.v = 1'b1;
    if (cls == 0) begin
      e.alu = 4'(op); e.rd = 5'(rd); e.wr = (rd != 0); e.b = mval(5'(rs));
      e.a = (op < 4) ? mval(5'(rd)) : mval(5'(rt));
    end else if (cls == 1) begin
      e.alu = 4'(op); e.rd = 5'(rd); e.wr = (rd != 0);
      e.a = (op < 4) ? mval(5'(rd)) : zext16;
      e.b = (op < 4) ? zext8 : mval(5'(rs));
    end else if (cls == 2) begin
      e.alu = 4'hE; e.rd = 5'(rd); e.a = sext; e.b = mval(5'(rs));
      if (op >= 8) begin e.mw = 1'b1; e.sd = mval(5'(rd)); end
      else begin e.mr = 1'b1; e.wr = (rd != 0); end
    end else if (op == 0) begin
      e.alu = 4'hF; e.a = sext; e.b = mval(5'(rs)); e.br = 1'b1;
    end
    return e;
  endfunction

  function automatic logic ref_uses(input logic [31:0] ins, input logic [4:0] r);
    int cls, op;
    logic u;
    cls = int'(ins[31:30]); op = int'(ins[29:26]);
    u = 1'b0;
    if (!(cls == 3 && op != 0) && ins[20:16] == r) u = 1'b1;
    if (cls == 0 && op >= 4 && ins[15:11] == r) u = 1'b1;
    if (((cls == 0 || cls == 1) && op < 4) || (cls == 2 && op >= 8))
      if (ins[25:21] == r) u = 1'b1;
    return u;
  endfunction

  task automatic clear_inputs();
    if_valid = 0; if_instr = '0; flush = 0; ex_hold = 0;
    ex_fwd_valid = 0; ex_fwd_rd = '0; ex_fwd_data = '0;
    mem_fwd_valid = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    chk("reset.if_ready", {31'd0, if_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  localparam exp_t BUBBLE = '0;

  initial begin
    exp_t m, nxt;
    logic haz;
    logic [31:0] ins;

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    rf[0] = 32'hDEAD_BEEF; rf[1] = 32'd10; rf[2] = 32'd3; rf[5] = 32'h1122_3344; rf[9] = 32'h99;

    do_reset();
    chk_all("reset", BUBBLE);
    chk("reset.halted", {31'd0, halted}, 32'd0);

    tbl.push_back('{"sub", mk_r(2'd0, 4'hD, 5'd4, 5'd1, 5'd2), 0, 0, 0, 0, 0, 0,
                   ex(4'hD, 32'd3, 32'd10, 5'd4, 1, 0, 0, 0, 0)});
    tbl.push_back('{"mv2", mk_i(2'd1, 4'h2, 5'd5, 5'd0, 16'h00AB), 0, 0, 0, 0, 0, 0,
                   ex(4'h2, 32'h1122_3344, 32'hAB, 5'd5, 1, 0, 0, 0, 0)});
    tbl.push_back('{"fwd_prio", mk_r(2'd0, 4'hE, 5'd6, 5'd3, 5'd2), 1, 5'd3, 32'h55, 1, 5'd3, 32'h66,
                   ex(4'hE, 32'd3, 32'h55, 5'd6, 1, 0, 0, 0, 0)});
    tbl.push_back('{"fwd_r0", mk_r(2'd0, 4'hB, 5'd7, 5'd0, 5'd1), 1, 5'd0, 32'h77, 1, 5'd0, 32'h88,
                   ex(4'hB, 32'd10, 32'd0, 5'd7, 1, 0, 0, 0, 0)});
    tbl.push_back('{"fwd_mem", mk_r(2'd0, 4'hA, 5'd8, 5'd3, 5'd1), 1, 5'd5, 32'h99, 1, 5'd3, 32'h66,
                   ex(4'hA, 32'd10, 32'h66, 5'd8, 1, 0, 0, 0, 0)});
    tbl.push_back('{"r_mv1", mk_r(2'd0, 4'h1, 5'd5, 5'd2, 5'd9), 0, 0, 0, 0, 0, 0,
                   ex(4'h1, 32'h1122_3344, 32'd3, 5'd5, 1, 0, 0, 0, 0)});
    tbl.push_back('{"i_add_rd0", mk_i(2'd1, 4'hE, 5'd0, 5'd1, 16'h8001), 0, 0, 0, 0, 0, 0,
                   ex(4'hE, 32'h0000_8001, 32'd10, 5'd0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"store", mk_i(2'd2, 4'h8, 5'd5, 5'd1, 16'hFFFC), 0, 0, 0, 0, 0, 0,
                   ex(4'hE, 32'hFFFF_FFFC, 32'd10, 5'd5, 0, 0, 1, 32'h1122_3344, 0)});
    tbl.push_back('{"branch", mk_i(2'd3, 4'h0, 5'd0, 5'd2, 16'h8000), 0, 0, 0, 0, 0, 0,
                   ex(4'hF, 32'hFFFF_8000, 32'd3, 5'd0, 0, 0, 0, 0, 1)});
    tbl.push_back('{"nop", mk_i(2'd3, 4'h5, 5'd4, 5'd1, 16'h1234), 0, 0, 0, 0, 0, 0,
                   ex(4'h0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"load", mk_i(2'd2, 4'h3, 5'd9, 5'd2, 16'h0010), 0, 0, 0, 0, 0, 0,
                   ex(4'hE, 32'h10, 32'd3, 5'd9, 1, 1, 0, 0, 0)});

    foreach (tbl[i]) begin
      if_valid = 1; if_instr = tbl[i].instr;
      ex_fwd_valid = tbl[i].exv; ex_fwd_rd = tbl[i].exrd; ex_fwd_data = tbl[i].exd;
      mem_fwd_valid = tbl[i].mv; mem_fwd_rd = tbl[i].mrd; mem_fwd_data = tbl[i].md;
      #1;
      chk({tbl[i].name, ".if_ready"}, {31'd0, if_ready}, 32'd1);
      tick();
      chk_all(tbl[i].name, tbl[i].e);
    end

    // Load-use: one bubble, then the consumer picks the load data off mem_fwd.
    do_reset();
    if_valid = 1; if_instr = mk_i(2'd2, 4'h0, 5'd7, 5'd1, 16'h0004);
    tick();
    chk_all("lu.load", ex(4'hE, 32'h4, 32'd10, 5'd7, 1, 1, 0, 0, 0));
    if_instr = mk_r(2'd0, 4'hE, 5'd10, 5'd7, 5'd2);
    #1;
    chk("lu.if_ready_stall", {31'd0, if_ready}, 32'd0);
    tick();
    chk("lu.bubble", {31'd0, ex_valid}, 32'd0);
    mem_fwd_valid = 1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'hCAFE_0001;
    #1;
    chk("lu.if_ready_resume", {31'd0, if_ready}, 32'd1);
    tick();
    chk_all("lu.use", ex(4'hE, 32'd3, 32'hCAFE_0001, 5'd10, 1, 0, 0, 0, 0));
    clear_inputs();

    // Flush in the STALL cycle drops the held consumer.
    if_valid = 1; if_instr = mk_i(2'd2, 4'h0, 5'd7, 5'd1, 16'h0004);
    tick();
    if_instr = mk_r(2'd0, 4'hE, 5'd10, 5'd7, 5'd2);
    tick();
    chk("fs.bubble1", {31'd0, ex_valid}, 32'd0);
    flush = 1;
    tick();
    chk("fs.bubble2", {31'd0, ex_valid}, 32'd0);
    flush = 0; if_instr = mk_r(2'd0, 4'hE, 5'd11, 5'd1, 5'd2);
    #1;
    chk("fs.if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    chk_all("fs.next", ex(4'hE, 32'd3, 32'd10, 5'd11, 1, 0, 0, 0, 0));

    // ex_hold freezes outputs; flush still wins over hold.
    if_instr = mk_r(2'd0, 4'hD, 5'd4, 5'd1, 5'd2);
    tick();
    ex_hold = 1; if_instr = mk_i(2'd1, 4'h2, 5'd5, 5'd0, 16'h00AB);
    #1;
    chk("hold.if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    chk_all("hold", ex(4'hD, 32'd3, 32'd10, 5'd4, 1, 0, 0, 0, 0));
    flush = 1;
    tick();
    chk("hold_flush.valid", {31'd0, ex_valid}, 32'd0);
    ex_hold = 0;

    // Halt offered with flush is discarded.
    if_instr = mk_r(2'd3, 4'hF, 5'd0, 5'd0, 5'd0);
    tick();
    chk("halt_flush.halted", {31'd0, halted}, 32'd0);
    flush = 0; if_valid = 0;
    #1;
    chk("halt_flush.if_ready", {31'd0, if_ready}, 32'd1);

    // Halt latches until reset.
    if_valid = 1;
    tick();
    chk("halt.halted", {31'd0, halted}, 32'd1);
    chk("halt.valid", {31'd0, ex_valid}, 32'd0);
    if_instr = mk_r(2'd0, 4'hD, 5'd4, 5'd1, 5'd2);
    #1;
    chk("halt.if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    chk("halt.still", {31'd0, halted}, 32'd1);
    chk("halt.valid2", {31'd0, ex_valid}, 32'd0);
    rst = 1;
    #1;
    chk("halt.rst_if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    rst = 0;
    chk("halt.rst_halted", {31'd0, halted}, 32'd0);
    chk_all("halt.rst", BUBBLE);

    // Random traffic against the model.
    do_reset();
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    m = '0;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      if (ins[31:26] == 6'b111111) ins[29:26] = 4'h1;
      if_instr = ins;
      if_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_hold = ($urandom_range(0, 9) == 0);
      ex_fwd_valid = $urandom_range(0, 1) != 0;
      ex_fwd_rd = 5'($urandom_range(0, 7));
      ex_fwd_data = $urandom;
      mem_fwd_valid = $urandom_range(0, 1) != 0;
      mem_fwd_rd = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      #1;
      haz = if_valid && m.v && m.mr && (m.rd != 0) && ref_uses(ins, m.rd);
      chk("rnd.if_ready", {31'd0, if_ready}, {31'd0, !haz && !ex_hold});
      if (flush) nxt = '0;
      else if (ex_hold) nxt = m;
      else if (haz || !if_valid) nxt = '0;
      else nxt = ref_decode(ins);
      tick();
      m = nxt;
      chk_all("rnd", m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
